// File: rtl/aemb_wb_arb.sv
// Two-master Wishbone arbiter: shares one memory port between the
// instruction and data masters of an AEMB core. Round-robin on
// contention, registered request path, combinational response path, and
// a slave-ack watchdog that abandons stalled cycles after TMO clocks.
module aemb_wb_arb #(
    parameter int AW  = 14,   // word-address width
    parameter int TMO = 255   // slave-ack timeout in clocks, 1..255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    // instruction master (read-only)
    input  logic          iwb_stb_i,
    input  logic [AW-1:0] iwb_adr_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    // data master
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    // shared memory port
    output logic          mem_stb_o,
    output logic          mem_wre_o,
    output logic [3:0]    mem_sel_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i,
    input  logic          mem_ack_i,
    // watchdog
    output logic          tmo_err_o
);

    // Counter value in the last cycle before the timeout fires.
    localparam logic [7:0] WAIT_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_d;       // 1: data master was served last
    logic [7:0] wait_cnt;     // cycles spent in the current grant without ack
    logic       grant_i;
    logic       grant_d;
    logic       release_bus;  // grant ends this cycle (ack or timeout)
    logic       expire;       // grant ends because the slave never answered

    // Next-state and grant decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        release_bus = 1'b0;
        expire      = 1'b0;
        case (state)
            IDLE: begin
                // Instruction wins when alone, or when both ask and data went last.
                if (iwb_stb_i && (!dwb_stb_i || last_d)) begin
                    grant_i   = 1'b1;
                    state_nxt = GNT_I;
                end else if (dwb_stb_i) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                // An ack in the final counted cycle still counts as completion.
                if (mem_ack_i) begin
                    release_bus = 1'b1;
                    state_nxt   = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    release_bus = 1'b1;
                    expire      = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!sys_rst_ni) state <= IDLE;
        else             state <= state_nxt;
    end

    // Memory request registers: loaded on grant, held until release.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            mem_stb_o <= 1'b0;
            mem_wre_o <= 1'b0;
            mem_sel_o <= 4'h0;
            mem_adr_o <= '0;
            mem_dat_o <= 32'h0;
        end else if (grant_i) begin
            mem_stb_o <= 1'b1;
            mem_wre_o <= 1'b0;
            mem_sel_o <= 4'hF;
            mem_adr_o <= iwb_adr_i;
            mem_dat_o <= 32'h0;
        end else if (grant_d) begin
            mem_stb_o <= 1'b1;
            mem_wre_o <= dwb_wre_i;
            mem_sel_o <= dwb_sel_i;
            mem_adr_o <= dwb_adr_i;
            mem_dat_o <= dwb_dat_i;
        end else if (release_bus) begin
            mem_stb_o <= 1'b0;
        end
    end

    // Wait counter, fairness memory and timeout pulse.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            wait_cnt  <= 8'h0;
            last_d    <= 1'b0;
            tmo_err_o <= 1'b0;
        end else begin
            tmo_err_o <= expire;
            if (grant_i || grant_d) begin
                wait_cnt <= 8'h0;
            end else if (state != IDLE && !mem_ack_i) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (release_bus) begin
                last_d <= (state == GNT_D);
            end
        end
    end

    // Response path is combinational; only the granted, still-requesting master sees ack.
    assign iwb_ack_o = mem_ack_i & (state == GNT_I) & iwb_stb_i;
    assign dwb_ack_o = mem_ack_i & (state == GNT_D) & dwb_stb_i;
    assign iwb_dat_o = mem_dat_i;
    assign dwb_dat_o = mem_dat_i;

endmodule

// File: tb/tb_aemb_wb_arb.sv
// Scoreboard bench for aemb_wb_arb: stimulus pushes expected memory
// requests, master read data and timeout pulses into queues; a monitor
// pops and compares whenever the DUT presents them.
module tb_aemb_wb_arb;

    localparam int AW  = 14;
    localparam int TMO = 4;

    typedef struct {
        logic [AW-1:0] adr;
        logic [3:0]    sel;
        logic          wre;
        logic [31:0]   dat;
    } mem_req_t;

    logic          clk;
    logic          rst_n;
    logic          iwb_stb_i;
    logic [AW-1:0] iwb_adr_i;
    logic [31:0]   iwb_dat_o;
    logic          iwb_ack_o;
    logic          dwb_stb_i;
    logic          dwb_wre_i;
    logic [3:0]    dwb_sel_i;
    logic [AW-1:0] dwb_adr_i;
    logic [31:0]   dwb_dat_i;
    logic [31:0]   dwb_dat_o;
    logic          dwb_ack_o;
    logic          mem_stb_o;
    logic          mem_wre_o;
    logic [3:0]    mem_sel_o;
    logic [AW-1:0] mem_adr_o;
    logic [31:0]   mem_dat_o;
    logic [31:0]   mem_dat_i;
    logic          mem_ack_i;
    logic          tmo_err_o;

    int checks   = 0;
    int failures = 0;
    int slave_lat = 1;   // ack in the Nth strobe cycle; 0 = never ack
    int tmo_exp   = 0;

    mem_req_t    mem_q[$];
    logic [31:0] iack_q[$];
    logic [31:0] dack_q[$];

    aemb_wb_arb #(.AW(AW), .TMO(TMO)) dut (
        .sys_clk_i (clk),
        .sys_rst_ni(rst_n),
        .iwb_stb_i (iwb_stb_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_dat_o (iwb_dat_o),
        .iwb_ack_o (iwb_ack_o),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_dat_o (dwb_dat_o),
        .dwb_ack_o (dwb_ack_o),
        .mem_stb_o (mem_stb_o),
        .mem_wre_o (mem_wre_o),
        .mem_sel_o (mem_sel_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_ack_i (mem_ack_i),
        .tmo_err_o (tmo_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave read data is a fixed function of the word address.
    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ 32'(a);
    endfunction

    task automatic push_mem(input logic [AW-1:0] adr, input logic [3:0] sel,
                            input logic wre, input logic [31:0] dat);
        mem_req_t r;
        r.adr = adr;
        r.sel = sel;
        r.wre = wre;
        r.dat = dat;
        mem_q.push_back(r);
    endtask

    // Instruction read; stb is left high so the caller can chain requests.
    task automatic i_xfer(input logic [AW-1:0] adr);
        bit got;
        got = 1'b0;
        iack_q.push_back(exp_rd(adr));
        iwb_adr_i = adr;
        iwb_stb_i = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = iwb_ack_o;
        end
        check("i_ack_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Data transfer; stb is left high so the caller can chain requests.
    task automatic d_xfer(input logic [AW-1:0] adr, input logic wre,
                          input logic [3:0] sel, input logic [31:0] dat);
        bit got;
        got = 1'b0;
        dack_q.push_back(exp_rd(adr));
        dwb_adr_i = adr;
        dwb_wre_i = wre;
        dwb_sel_i = sel;
        dwb_dat_i = dat;
        dwb_stb_i = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = dwb_ack_o;
        end
        check("d_ack_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_stb"}, 32'(mem_stb_o), 32'd0);
        check({tag, "_mem_wre"}, 32'(mem_wre_o), 32'd0);
        check({tag, "_mem_sel"}, 32'(mem_sel_o), 32'd0);
        check({tag, "_mem_adr"}, 32'(mem_adr_o), 32'd0);
        check({tag, "_mem_dat"}, mem_dat_o, 32'd0);
        check({tag, "_tmo_err"}, 32'(tmo_err_o), 32'd0);
        check({tag, "_iwb_ack"}, 32'(iwb_ack_o), 32'd0);
        check({tag, "_dwb_ack"}, 32'(dwb_ack_o), 32'd0);
    endtask

    // Memory slave model: acks in the slave_lat-th cycle of a strobe.
    initial begin
        int hi;
        hi = 0;
        mem_ack_i = 1'b0;
        mem_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_stb_o) hi++;
            else           hi = 0;
            mem_ack_i = (slave_lat != 0) && (hi == slave_lat);
            mem_dat_i = 32'hC0DE_0000 ^ 32'(mem_adr_o);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        bit          prev_stb;
        mem_req_t    cur;
        logic [31:0] ev;
        prev_stb = 1'b0;
        cur.adr = '0;
        cur.sel = 4'h0;
        cur.wre = 1'b0;
        cur.dat = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stb = 1'b0;
            end else begin
                if (mem_stb_o) begin
                    if (!prev_stb) begin
                        check("mem_req_expected", 32'(mem_q.size() != 0), 32'd1);
                        if (mem_q.size() != 0) cur = mem_q.pop_front();
                    end
                    // Compared on every strobe cycle, so a field changing mid-cycle is caught.
                    check("mem_adr", 32'(mem_adr_o), 32'(cur.adr));
                    check("mem_sel", 32'(mem_sel_o), 32'(cur.sel));
                    check("mem_wre", 32'(mem_wre_o), 32'(cur.wre));
                    check("mem_dat", mem_dat_o, cur.dat);
                end
                prev_stb = mem_stb_o;
                if (iwb_ack_o) begin
                    check("iwb_ack_expected", 32'(iack_q.size() != 0), 32'd1);
                    if (iack_q.size() != 0) begin
                        ev = iack_q.pop_front();
                        check("iwb_dat", iwb_dat_o, ev);
                    end
                end
                if (dwb_ack_o) begin
                    check("dwb_ack_expected", 32'(dack_q.size() != 0), 32'd1);
                    if (dack_q.size() != 0) begin
                        ev = dack_q.pop_front();
                        check("dwb_dat", dwb_dat_o, ev);
                    end
                end
                if (tmo_err_o) begin
                    check("tmo_expected", 32'(tmo_exp > 0), 32'd1);
                    if (tmo_exp > 0) tmo_exp--;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit seen;
        bit done;
        int cnt;

        rst_n     = 1'b0;
        iwb_stb_i = 1'b0;
        iwb_adr_i = '0;
        dwb_stb_i = 1'b0;
        dwb_wre_i = 1'b0;
        dwb_sel_i = 4'h0;
        dwb_adr_i = '0;
        dwb_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Contention straight after reset: data first, then strict alternation.
        @(posedge clk);
        #1;
        slave_lat = 1;
        push_mem(14'h0200, 4'h3, 1'b1, 32'hDEAD_0001);
        push_mem(14'h0040, 4'hF, 1'b0, 32'h0);
        push_mem(14'h0204, 4'hF, 1'b0, 32'h1234_5678);
        push_mem(14'h0041, 4'hF, 1'b0, 32'h0);
        fork
            begin
                d_xfer(14'h0200, 1'b1, 4'h3, 32'hDEAD_0001);
                d_xfer(14'h0204, 1'b0, 4'hF, 32'h1234_5678);
                dwb_stb_i = 1'b0;
            end
            begin
                i_xfer(14'h0040);
                i_xfer(14'h0041);
                iwb_stb_i = 1'b0;
            end
        join

        // Single instruction read, slave acks two cycles after strobe.
        @(posedge clk);
        #1;
        slave_lat = 3;
        push_mem(14'h0010, 4'hF, 1'b0, 32'h0);
        i_xfer(14'h0010);
        iwb_stb_i = 1'b0;

        // Byte-lane write.
        @(posedge clk);
        #1;
        push_mem(14'h0100, 4'h4, 1'b1, 32'h1122_3344);
        d_xfer(14'h0100, 1'b1, 4'h4, 32'h1122_3344);
        dwb_stb_i = 1'b0;

        // Ack while idle is ignored; ack in the final counted cycle completes normally.
        @(negedge clk);
        slave_lat = TMO;
        push_mem(14'h0123, 4'hF, 1'b0, 32'h0);
        iwb_adr_i = 14'h0123;
        iwb_stb_i = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        check("idle_ack_iwb", 32'(iwb_ack_o), 32'd0);
        check("idle_ack_dwb", 32'(dwb_ack_o), 32'd0);
        i_xfer(14'h0123);
        iwb_stb_i = 1'b0;

        // Data master withdraws mid-grant: the memory cycle completes, no ack forwarded.
        @(posedge clk);
        #1;
        slave_lat = 3;
        push_mem(14'h0180, 4'h8, 1'b1, 32'h55AA_0000);
        dwb_adr_i = 14'h0180;
        dwb_wre_i = 1'b1;
        dwb_sel_i = 4'h8;
        dwb_dat_i = 32'h55AA_0000;
        dwb_stb_i = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = mem_stb_o;
        end
        check("drop_grant_seen", 32'(seen), 32'd1);
        dwb_stb_i = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            done = !mem_stb_o;
        end
        check("drop_cycle_completed", 32'(done), 32'd1);

        // Timeout: slave never acks.
        @(posedge clk);
        #1;
        slave_lat = 0;
        push_mem(14'h0333, 4'hF, 1'b0, 32'h0);
        tmo_exp++;
        iwb_adr_i = 14'h0333;
        iwb_stb_i = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (mem_stb_o) cnt++;
            if (tmo_err_o) begin
                seen      = 1'b1;
                iwb_stb_i = 1'b0;
            end
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_stb_cycles", 32'(cnt), 32'(TMO));
        repeat (2) @(negedge clk);
        check("tmo_no_regrant", 32'(mem_stb_o), 32'd0);
        check("tmo_single_pulse", 32'(tmo_err_o), 32'd0);

        // Normal request after a timeout.
        @(posedge clk);
        #1;
        slave_lat = 1;
        push_mem(14'h0104, 4'h2, 1'b1, 32'h0BAD_F00D);
        d_xfer(14'h0104, 1'b1, 4'h2, 32'h0BAD_F00D);
        dwb_stb_i = 1'b0;

        // Reset in the middle of a grant, then contention goes to data.
        @(posedge clk);
        #1;
        slave_lat = 0;
        push_mem(14'h0055, 4'hF, 1'b0, 32'h0);
        iwb_adr_i = 14'h0055;
        iwb_stb_i = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = mem_stb_o;
        end
        check("rst_grant_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        slave_lat = 1;
        push_mem(14'h0300, 4'h1, 1'b1, 32'hA5A5_A5A5);
        push_mem(14'h0056, 4'hF, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            begin
                d_xfer(14'h0300, 1'b1, 4'h1, 32'hA5A5_A5A5);
                dwb_stb_i = 1'b0;
            end
            begin
                i_xfer(14'h0056);
                iwb_stb_i = 1'b0;
            end
        join

        repeat (3) @(posedge clk);
        #1;
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check("iack_q_drained", 32'(iack_q.size()), 32'd0);
        check("dack_q_drained", 32'(dack_q.size()), 32'd0);
        check("tmo_drained", 32'(tmo_exp), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aemb_wb_arb.md
AEMB_WB_ARB -- requirements
Module: aemb_wb_arb

Interface
REQ-001 SHALL have parameter AW, default 14, word-address width (byte address bits [AW+1:2]).
REQ-002 SHALL have parameter TMO, default 255, legal range 1..255, slave-ack timeout in clock cycles.
REQ-003 SHALL have port sys_clk_i  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port sys_rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iwb_stb_i  in  1  instruction master read request.
REQ-006 SHALL have port iwb_adr_i  in  AW  instruction word address.
REQ-007 SHALL have port iwb_dat_o  out  32  instruction read data.
REQ-008 SHALL have port iwb_ack_o  out  1  instruction transfer done.
REQ-009 SHALL have port dwb_stb_i  in  1  data master request.
REQ-010 SHALL have port dwb_wre_i  in  1  data write enable.
REQ-011 SHALL have port dwb_sel_i  in  4  data byte-lane select.
REQ-012 SHALL have port dwb_adr_i  in  AW  data word address.
REQ-013 SHALL have port dwb_dat_i  in  32  data write data.
REQ-014 SHALL have port dwb_dat_o  out  32  data read data.
REQ-015 SHALL have port dwb_ack_o  out  1  data transfer done.
REQ-016 SHALL have ports mem_stb_o/mem_wre_o (out 1), mem_sel_o (out 4), mem_adr_o (out AW), mem_dat_o (out 32): shared memory request.
REQ-017 SHALL have ports mem_dat_i (in 32) and mem_ack_i (in 1): shared memory response.
REQ-018 SHALL have port tmo_err_o  out  1  one-cycle timeout pulse.

Function
REQ-019 SHALL implement FSM states IDLE, GNT_I, GNT_D; exactly one master granted at a time.
REQ-020 IDLE: only iwb_stb_i -> GNT_I; only dwb_stb_i -> GNT_D; both -> master not served last (rLAST); neither -> stay.
REQ-021 On entering GNT_x SHALL register that master's adr/sel/wre/dat onto mem_* and assert mem_stb_o; request sampled at edge N gives mem_stb_o high after edge N (one-cycle latency).
REQ-022 Instruction grant SHALL drive mem_wre_o=0, mem_sel_o=4'hF, mem_dat_o=0.
REQ-023 mem_* outputs SHALL stay stable while mem_stb_o high until ack or timeout.
REQ-024 x_ack_o SHALL equal mem_ack_i & (state==GNT_x) & x_stb_i, combinationally; never asserted for the ungranted master.
REQ-025 iwb_dat_o and dwb_dat_o SHALL pass mem_dat_i through unregistered.
REQ-026 On mem_ack_i in GNT_x: next state IDLE, mem_stb_o low next cycle, rLAST<=x; minimum one IDLE cycle between grants.
REQ-027 Master dropping stb mid-grant: memory cycle SHALL still complete; no ack forwarded.
REQ-028 8-bit wait counter SHALL clear on grant, increment each GNT cycle without mem_ack_i; on reaching TMO: tmo_err_o=1 for one cycle, mem_stb_o low, state IDLE, rLAST<=x, no master ack.
REQ-029 mem_ack_i in the same cycle the counter reaches TMO SHALL count as normal completion (no error).
REQ-030 mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-031 While sys_rst_ni=0: state IDLE, mem_stb_o=0, mem_wre_o=0, mem_sel_o=0, mem_adr_o=0, mem_dat_o=0, tmo_err_o=0, counter=0, rLAST=instruction (first contention goes to data).
REQ-032 Reset asserted mid-grant SHALL drop mem_stb_o immediately, asynchronously, without acking either master.

Verification
REQ-033 Single read: iwb_stb_i=1, adr=0x0010; mem_ack_i 2 cycles after mem_stb_o -> mem_adr_o=0x0010, sel=F, wre=0; iwb_ack_o one cycle with iwb_dat_o=mem_dat_i.
REQ-034 Contention after reset: both stb at cycle 0 -> data served first, then instruction; with both held: D,I,D,I strict alternation.
REQ-035 Byte write: dwb_wre_i=1, sel=4'h4, dat=0x11223344, adr=0x0100 -> mem_* identical, held until ack; dwb_ack_o single cycle.
REQ-036 Timeout TMO=4, slave never acks -> mem_stb_o high exactly 4 cycles, tmo_err_o pulse, no acks, next request granted normally.
REQ-037 Reset mid-grant: sys_rst_ni low while mem_stb_o=1 -> all outputs to reset values same cycle; after release first contention grants data.
